// File: rtl/scalar_execute_mc.sv
// -----------------------------------------------------------------------------
// scalar_execute_mc
//
// Scalar execute stage with a valid/ready handshake on both sides. Single-cycle
// ALU operations (add, sub, logic, shifts, move) produce a result one edge after
// acceptance; MUL runs an unsigned shift-add multiplier for WIDTH steps plus one
// finalise edge. The result is held in HOLD until the consumer takes it.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-high reset
//   flush      : synchronous abort of any in-flight operation (highest priority)
//   in_valid   : request fields are valid
//   in_ready   : block can accept a request this cycle
//   data1      : operand A
//   data2      : register operand B
//   immediate  : immediate operand, sign-extended to WIDTH when use_imm = 1
//   use_imm    : select immediate (1) or data2 (0) as operand B
//   op         : operation select (0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SHL,6 SHR,
//                7 SRA,8 MUL, 9..15 MOV)
//   out_valid  : data_out and flags are valid
//   out_ready  : consumer accepts the result
//   data_out   : result
//   zero/sign/overflow : result flags
// -----------------------------------------------------------------------------
module scalar_execute_mc #(
   parameter int WIDTH     = 36,
   parameter int IMM_WIDTH = 25
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     data1,
   input  logic [WIDTH-1:0]     data2,
   input  logic [IMM_WIDTH-1:0] immediate,
   input  logic                 use_imm,
   input  logic [3:0]           op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     data_out,
   output logic                 zero,
   output logic                 sign,
   output logic                 overflow
);

   localparam int SH_W  = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int MSB   = WIDTH - 1;

   // Shift amounts are compared one bit wider so WIDTH itself is representable.
   localparam logic [SH_W:0]    WIDTH_SH = (SH_W + 1)'(WIDTH);
   // The counter runs 0..WIDTH: WIDTH step edges, then one finalise edge.
   localparam logic [CNT_W-1:0] MUL_DONE = CNT_W'(WIDTH);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_SHR = 4'd6;
   localparam logic [3:0] OP_SRA = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_MUL = 2'd1,
      HOLD     = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     res_q, res_d;
   logic                 ovf_q, ovf_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   // ---------------------------------------------------------------------------
   // Operand selection and single-cycle ALU (evaluated on the live request so the
   // result is captured on the acceptance edge).
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] imm_ext;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [SH_W:0]    shamt;
   logic             shamt_big;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;

   assign imm_ext   = WIDTH'($signed(immediate));
   assign opb       = use_imm ? imm_ext : data2;
   assign sum       = data1 + opb;
   assign diff      = data1 - opb;
   assign shamt     = {1'b0, opb[SH_W-1:0]};
   assign shamt_big = (shamt >= WIDTH_SH);

   // NOTE: every combinational output gets a default before the case so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      alu_res = data1;
      alu_ovf = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (data1[MSB] == opb[MSB]) && (sum[MSB] != data1[MSB]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (data1[MSB] != opb[MSB]) && (diff[MSB] != data1[MSB]);
         end
         OP_AND: alu_res = data1 & opb;
         OP_OR:  alu_res = data1 | opb;
         OP_XOR: alu_res = data1 ^ opb;
         OP_SHL: alu_res = shamt_big ? '0 : (data1 << shamt[SH_W-1:0]);
         OP_SHR: alu_res = shamt_big ? '0 : (data1 >> shamt[SH_W-1:0]);
         OP_SRA: alu_res = shamt_big ? {WIDTH{data1[MSB]}}
                                     : WIDTH'($signed(data1) >>> shamt[SH_W-1:0]);
         default: alu_res = data1;  // MOV for 9..15; MUL goes through the multiplier
      endcase
   end

   // ---------------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------------
   logic accept;

   assign in_ready  = !flush && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == HOLD);
   assign data_out  = res_q;
   assign zero      = (res_q == '0);
   assign sign      = res_q[MSB];
   assign overflow  = ovf_q;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      res_d    = res_q;
      ovf_d    = ovf_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;

      if (flush) begin
         // Abort wins over everything; the stale result is simply never shown.
         state_d = IDLE;
      end else begin
         case (state_q)
            BUSY_MUL: begin
               if (cnt_q == MUL_DONE) begin
                  state_d = HOLD;
                  res_d   = acc_q[WIDTH-1:0];
                  ovf_d   = |acc_q[2*WIDTH-1:WIDTH];
               end else begin
                  if (mplier_q[0]) begin
                     acc_d = acc_q + mcand_q;
                  end
                  mcand_d  = mcand_q << 1;
                  mplier_d = mplier_q >> 1;
                  cnt_d    = cnt_q + 1'b1;
               end
            end
            HOLD: begin
               if (out_ready && !accept) begin
                  state_d = IDLE;
               end
            end
            default: ;  // IDLE: only leaves on acceptance, handled below
         endcase

         // Acceptance is only possible in IDLE or in HOLD while the result drains,
         // so it overrides the per-state choice above.
         if (accept) begin
            if (op == OP_MUL) begin
               state_d  = BUSY_MUL;
               mcand_d  = {{WIDTH{1'b0}}, data1};
               mplier_d = opb;
               acc_d    = '0;
               cnt_d    = '0;
            end else begin
               state_d = HOLD;
               res_d   = alu_res;
               ovf_d   = alu_ovf;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         res_q    <= '0;
         ovf_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         res_q    <= res_d;
         ovf_q    <= ovf_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_scalar_execute_mc.sv
// -----------------------------------------------------------------------------
// tb_scalar_execute_mc
//
// Directed bench for scalar_execute_mc. A transaction-level model (expected
// result per accepted request, a countdown for the multiply latency, and a
// pending/held result slot) is compared against the DUT on every falling edge.
// Hand-computed literal checks pin the model on the key vectors.
// -----------------------------------------------------------------------------
module tb_scalar_execute_mc;

   localparam int W  = 36;
   localparam int IW = 25;
   localparam int SH = $clog2(W);

   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
   localparam logic [3:0] SHL = 4'd5, SHR = 4'd6, SRA = 4'd7, MUL = 4'd8, MOV = 4'd9;

   logic          clk, rst, flush, in_valid, in_ready, use_imm;
   logic [W-1:0]  data1, data2, data_out;
   logic [IW-1:0] immediate;
   logic [3:0]    op;
   logic          out_valid, out_ready, zero, sign, overflow;

   scalar_execute_mc #(.WIDTH(W), .IMM_WIDTH(IW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .data1(data1), .data2(data2), .immediate(immediate),
      .use_imm(use_imm), .op(op),
      .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .zero(zero), .sign(sign), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference arithmetic from the operation definitions
   // ---------------------------------------------------------------------------
   function automatic longint to_signed(input logic [W-1:0] v);
      longint x;
      x = longint'(v);
      if (v[W-1]) x = x - (longint'(1) << W);
      return x;
   endfunction

   function automatic void model_op(input logic [3:0] o, input logic [W-1:0] a,
                                    input logic [W-1:0] d2, input logic [IW-1:0] im,
                                    input logic ui, output logic [W-1:0] r,
                                    output logic ov);
      logic [W-1:0]   b;
      logic [2*W-1:0] p;
      longint         s, lo, hi, sh;
      int             amt;
      b = W'(im);
      if (im[IW-1]) b = b | ~((W'(1) << IW) - W'(1));
      if (!ui) b = d2;
      lo  = -(longint'(1) << (W - 1));
      hi  = (longint'(1) << (W - 1)) - 1;
      amt = int'(b[SH-1:0]);
      ov  = 1'b0;
      case (o)
         ADD: begin s = to_signed(a) + to_signed(b); r = a + b; ov = (s < lo) || (s > hi); end
         SUB: begin s = to_signed(a) - to_signed(b); r = a - b; ov = (s < lo) || (s > hi); end
         AND_: r = a & b;
         OR_:  r = a | b;
         XOR_: r = a ^ b;
         SHL:  r = (amt >= W) ? '0 : (a << amt);
         SHR:  r = (amt >= W) ? '0 : (a >> amt);
         SRA: begin
            sh = to_signed(a) >>> ((amt >= W) ? W : amt);
            r  = W'(sh);
         end
         MUL: begin
            p  = a * b;
            r  = p[W-1:0];
            ov = (p[2*W-1:W] != '0);
         end
         default: r = a;
      endcase
   endfunction

   // ---------------------------------------------------------------------------
   // Transaction model: a held result slot plus a pending multiply countdown.
   // ---------------------------------------------------------------------------
   bit           m_vld;
   int           m_pend;
   logic [W-1:0] m_data, m_pdata;
   logic         m_ovf, m_povf;

   function automatic bit model_ready();
      return !flush && ((!m_vld && m_pend < 0) || (m_vld && out_ready));
   endfunction

   always @(posedge clk or posedge rst) begin : model_upd
      bit           acc;
      logic [W-1:0] r;
      logic         ov;
      if (rst) begin
         m_vld  = 1'b0;
         m_pend = -1;
         m_data = '0;
         m_ovf  = 1'b0;
      end else begin
         acc = in_valid && model_ready();
         if (flush) begin
            m_vld  = 1'b0;
            m_pend = -1;
         end else begin
            if (m_vld && out_ready) m_vld = 1'b0;
            if (m_pend > 0) begin
               m_pend--;
               if (m_pend == 0) begin
                  m_vld  = 1'b1;
                  m_data = m_pdata;
                  m_ovf  = m_povf;
                  m_pend = -1;
               end
            end
            if (acc) begin
               model_op(op, data1, data2, immediate, use_imm, r, ov);
               if (op == MUL) begin
                  m_pend  = W + 1;
                  m_pdata = r;
                  m_povf  = ov;
               end else begin
                  m_vld  = 1'b1;
                  m_data = r;
                  m_ovf  = ov;
               end
            end
         end
      end
   end

   // Compare process: away from the active edge, every cycle.
   always @(negedge clk) begin
      if (!rst) begin
         check("in_ready", in_ready, model_ready());
         check("out_valid", out_valid, m_vld);
         if (m_vld) begin
            check("data_out", data_out, m_data);
            check("zero", zero, m_data == '0);
            check("sign", sign, m_data[W-1]);
            check("overflow", overflow, m_ovf);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers. Called in the drive phase (#1 after a rising edge); they
   // return in the drive phase just after the acceptance edge.
   // ---------------------------------------------------------------------------
   task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [IW-1:0] im, input logic ui, output int tries);
      bit rdy;
      in_valid  = 1'b1;
      op        = o;
      data1     = a;
      data2     = b;
      immediate = im;
      use_imm   = ui;
      tries     = 0;
      rdy       = 1'b0;
      while (!rdy && tries < 200) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         tries++;
      end
      if (!rdy) check("send_timeout", 64'd0, 64'd1);
      // Scramble the request fields so a late capture would be visible.
      in_valid  = 1'b0;
      op        = 4'($urandom_range(0, 15));
      data1     = W'({$urandom(), $urandom()});
      data2     = W'({$urandom(), $urandom()});
      immediate = IW'($urandom());
      use_imm   = 1'($urandom());
   endtask

   task automatic wait_valid(output int edges, output bit ready_seen);
      edges      = 0;
      ready_seen = in_ready;
      while (!out_valid && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
         if (!out_valid) ready_seen = ready_seen | in_ready;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin : stim
      int           tries, edges;
      bit           seen;
      logic [W-1:0] snap;

      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      data1 = '0; data2 = '0; immediate = '0; use_imm = 1'b0; op = '0;
      #1 rst = 1'b1;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_data_out", data_out, 0);
      check("rst_zero", zero, 1);
      check("rst_sign", sign, 0);
      check("rst_overflow", overflow, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", in_ready, 1);
      @(posedge clk);
      #1;

      // Signed-overflowing ADD
      send(ADD, 36'h7FFFFFFFF, 36'h1, '0, 1'b0, tries);
      check("add_valid", out_valid, 1);
      check("add_data", data_out, 36'h800000000);
      check("add_sign", sign, 1);
      check("add_ovf", overflow, 1);
      check("add_zero", zero, 0);

      // SUB with sign-extended immediate -1
      send(SUB, 36'd5, 36'h123, 25'h1FFFFFF, 1'b1, tries);
      check("subi_data", data_out, 36'd6);
      check("subi_ovf", overflow, 0);

      // A spread of ops back to back (checked by the model)
      send(SUB, 36'h800000000, 36'd1, '0, 1'b0, tries);
      send(AND_, 36'hF0F0F0F0F, 36'h0FF00FF00, '0, 1'b0, tries);
      send(OR_,  36'hF0F0F0F0F, 36'h0FF00FF00, '0, 1'b0, tries);
      send(XOR_, 36'hF0F0F0F0F, 36'h0FF00FF00, '0, 1'b0, tries);
      send(MOV,  36'hABCDE1234, 36'h0, '0, 1'b0, tries);
      send(4'd15, 36'h000000000, 36'h5, '0, 1'b0, tries);
      send(SHR,  36'h800000000, 36'd4, '0, 1'b0, tries);
      send(SHL,  36'h000000001, 36'h0, 25'd35, 1'b1, tries);
      send(ADD,  36'h0000000FF, 36'h0, 25'h1FFFF01, 1'b1, tries);

      // Shift boundaries
      send(SRA, 36'h800000000, 36'd40, '0, 1'b0, tries);
      check("sra_big", data_out, 36'hFFFFFFFFF);
      send(SHL, 36'h123456789, 36'd36, '0, 1'b0, tries);
      check("shl_36", data_out, 36'h0);
      send(SRA, 36'h800000000, 36'd35, '0, 1'b0, tries);
      send(SRA, 36'h400000000, 36'd3, '0, 1'b0, tries);

      // MUL: latency and upper-half overflow
      send(MUL, 36'h100000000, 36'h10, '0, 1'b0, tries);
      wait_valid(edges, seen);
      check("mul_latency", edges, W + 1);
      check("mul_busy_ready", seen, 0);
      check("mul_data", data_out, 36'h0);
      check("mul_zero", zero, 1);
      check("mul_ovf", overflow, 1);
      send(MUL, 36'd123456, 36'd7890, '0, 1'b0, tries);
      wait_valid(edges, seen);
      check("mul2_data", data_out, 36'd974067840);
      send(MUL, 36'hFFFFFFFFF, 36'h0, 25'h1FFFFFF, 1'b1, tries);
      wait_valid(edges, seen);

      // Backpressure: result held, then drained on the same edge as a new accept
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(XOR_, 36'hF0F0F0F0F, 36'h0FF00FF00, '0, 1'b0, tries);
      snap = data_out;
      check("bp_data", snap, 36'hFF00FF00F);
      repeat (5) begin
         @(posedge clk);
         #1;
         check("bp_stable", data_out, snap);
         check("bp_valid", out_valid, 1);
         check("bp_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      send(ADD, 36'd100, 36'd23, '0, 1'b0, tries);
      check("bp_no_bubble", tries, 1);
      check("bp_new_valid", out_valid, 1);
      check("bp_new_data", data_out, 36'd123);

      // Flush at cycle 10 of a MUL
      send(MUL, 36'd3, 36'd5, '0, 1'b0, tries);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      flush    = 1'b1;
      in_valid = 1'b1;
      op       = ADD;
      @(negedge clk);
      check("flush_ready", in_ready, 0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("post_flush_ready", in_ready, 1);
      seen = 1'b0;
      repeat (50) begin
         @(posedge clk);
         #1 seen = seen | out_valid;
      end
      check("flush_no_valid", seen, 0);

      // Reset in the middle of a MUL, with a nonzero held result beforehand
      send(ADD, 36'h7FFFFFFFF, 36'h1, '0, 1'b0, tries);
      send(MUL, 36'd7, 36'd9, '0, 1'b0, tries);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      check("pre_rst_data", data_out, 36'h800000000);
      #2 rst = 1'b1;
      #1;
      check("rst2_out_valid", out_valid, 0);
      check("rst2_data_out", data_out, 0);
      check("rst2_zero", zero, 1);
      check("rst2_sign", sign, 0);
      check("rst2_overflow", overflow, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst2", in_ready, 1);
      seen = 1'b0;
      repeat (45) begin
         @(posedge clk);
         #1 seen = seen | out_valid;
      end
      check("rst_no_valid", seen, 0);

      // Still functional afterwards
      send(SUB, 36'd10, 36'd3, '0, 1'b0, tries);
      check("final_data", data_out, 36'd7);
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/scalar_execute_mc.md
SCALAR_EXECUTE_MC -- requirements
Module: scalar_execute_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 36: datapath width in bits; legal range 8 to 64.
REQ-002 SHALL have parameter IMM_WIDTH, default 25: immediate width; must be less than or equal to WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port flush, input, 1 bit: synchronous abort of any in-flight operation.
REQ-006 SHALL have port in_valid, input, 1 bit: the request fields are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a request this cycle.
REQ-008 SHALL have port data1, input, WIDTH bits: operand A.
REQ-009 SHALL have port data2, input, WIDTH bits: register operand B.
REQ-010 SHALL have port immediate, input, IMM_WIDTH bits: immediate operand.
REQ-011 SHALL have port use_imm, input, 1 bit: when 1, operand B is the sign-extended immediate; when 0, operand B is data2.
REQ-012 SHALL have port op, input, 4 bits: operation select.
REQ-013 SHALL have port out_valid, output, 1 bit: the result and flags are valid.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-015 SHALL have port data_out, output, WIDTH bits: the result.
REQ-016 SHALL have ports zero, sign and overflow, outputs, 1 bit each: the result flags.

Function
REQ-017 SHALL decode op as follows:
- 0 = ADD, 1 = SUB, 2 = AND, 3 = OR, 4 = XOR;
- 5 = SHL, 6 = SHR (logical), 7 = SRA (arithmetic), 8 = MUL;
- 9 to 15 = MOV (result is data1).
REQ-018 SHALL treat the shift amount as unsigned operand B bits [clog2(WIDTH)-1:0]; an amount of WIDTH or more SHALL give 0 for SHL and SHR, and WIDTH copies of data1's MSB for SRA.
REQ-019 SHALL compute MUL as an unsigned iterative shift-add, one partial step per cycle for WIDTH cycles.
REQ-020 SHALL return the low WIDTH bits of the 2*WIDTH-bit product as the MUL result.
REQ-021 SHALL implement a state machine with states IDLE, BUSY_MUL and HOLD.
REQ-022 SHALL transition as follows:
- IDLE to HOLD on acceptance of a non-MUL op;
- IDLE to BUSY_MUL on acceptance of MUL;
- BUSY_MUL to HOLD after WIDTH steps;
- HOLD to IDLE when out_ready is 1 and no new request is accepted;
- HOLD to HOLD or BUSY_MUL when out_ready is 1 and a new request is accepted in the same cycle.
REQ-023 SHALL drive in_ready = !flush and (state is IDLE, or state is HOLD with out_ready = 1); a request is accepted on a rising edge where in_valid and in_ready are both 1.
REQ-024 SHALL assert out_valid only in HOLD, and SHALL raise it on the first rising edge after acceptance of a non-MUL op (latency 1).
REQ-025 SHALL raise out_valid for MUL exactly WIDTH+1 rising edges after acceptance (latency WIDTH+1).
REQ-026 SHALL hold data_out, zero, sign and overflow stable while out_valid is 1 and out_ready is 0.
REQ-027 SHALL set zero = 1 when data_out is 0, and sign = data_out[WIDTH-1].
REQ-028 SHALL set overflow per operation:
- ADD and SUB: two's-complement signed overflow;
- MUL: 1 if the upper WIDTH bits of the product are nonzero;
- all other ops: 0.
REQ-029 SHALL give flush priority over all other events: on a flush edge, state goes to IDLE, out_valid goes to 0, any result is discarded, and no request is accepted in that cycle.
REQ-030 SHALL capture operands at acceptance; changes on data1, data2, immediate, op or use_imm after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-031 SHALL, on assertion of rst and without waiting for a clock edge, force:
- state to IDLE;
- out_valid to 0;
- data_out to 0;
- zero to 1;
- sign to 0;
- overflow to 0;
- the multiply counter and accumulator to 0.
REQ-032 SHALL discard any in-flight MUL if rst is asserted during it, and SHALL drive in_ready = 1 on the first cycle after rst deasserts (when flush is 0).

Verification
REQ-033 Bench SHALL cover ADD: data1 = 0x7FFFFFFFF, data2 = 1, use_imm = 0, out_ready = 1 -> one cycle later out_valid = 1, data_out = 0x800000000, sign = 1, overflow = 1, zero = 0.
REQ-034 Bench SHALL cover immediate SUB: data1 = 5, immediate = 0x1FFFFFF (-1), use_imm = 1 -> data_out = 6, overflow = 0.
REQ-035 Bench SHALL cover MUL: data1 = 0x100000000, data2 = 0x10 -> out_valid exactly 37 edges after acceptance, data_out = 0, zero = 1, overflow = 1; in_ready = 0 throughout BUSY_MUL.
REQ-036 Bench SHALL cover shifts: SRA with data1 = 0x800000000 and shift amount 40 -> data_out = 0xFFFFFFFFF; SHL by 36 -> 0.
REQ-037 Bench SHALL cover backpressure: out_ready = 0 for 5 cycles -> outputs stable and in_ready = 0; then out_ready = 1 together with a new valid request -> the request is accepted on the same edge, with no bubble.
REQ-038 Bench SHALL cover abort mid-MUL: flush pulse at cycle 10 of a MUL -> out_valid never asserts for it and in_ready = 1 on the next cycle; repeat using rst instead -> all REQ-031 values appear immediately.
